// File: rtl/hazard_forward_unit_pkg.sv
// Shared widths, forwarding encodings and the destination-slot record used by
// the hazard/forwarding shadow pipeline.
package hazard_forward_unit_pkg;

    localparam int REG_AW = 5;
    localparam int FWD_W  = 2;

    localparam logic [FWD_W-1:0]  FWD_RF   = 2'b00;
    localparam logic [FWD_W-1:0]  FWD_MEM  = 2'b10;
    localparam logic [FWD_W-1:0]  FWD_WB   = 2'b01;
    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_AW-1:0] dst;
        logic              rw;
        logic              mr;
        logic              v;
    } dst_slot_t;

    // $0 is hardwired, so a write to it never creates a dependency.
    function automatic logic slot_writes(dst_slot_t s, logic [REG_AW-1:0] r);
        return s.v & s.rw & (s.dst == r) & (r != REG_ZERO);
    endfunction

endpackage

// File: rtl/hazard_forward_unit_dst.sv
// One destination-tracking stage {dst, rw, mr, v}; used for MEM and WB.
module dst_slot
    import hazard_forward_unit_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [REG_AW-1:0] d_dst,
    input  logic              d_rw,
    input  logic              d_mr,
    input  logic              d_v,
    output logic [REG_AW-1:0] q_dst,
    output logic              q_rw,
    output logic              q_mr,
    output logic              q_v
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_dst <= REG_ZERO;
            q_rw  <= 1'b0;
            q_mr  <= 1'b0;
            q_v   <= 1'b0;
        end else begin
            q_dst <= d_dst;
            q_rw  <= d_rw;
            q_mr  <= d_mr;
            q_v   <= d_v;
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Shadow EX->MEM->WB register tracker producing load-use/branch stalls and
// EX / ID-branch forwarding selects for the 5-stage datapath.
module hazard_forward_unit
    import hazard_forward_unit_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_is_branch,
    input  logic [REG_AW-1:0] ex_dst,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic              flush,
    output logic              stall,
    output logic [FWD_W-1:0]  fwd_a,
    output logic [FWD_W-1:0]  fwd_b,
    output logic              fwd_br_a,
    output logic              fwd_br_b
);

    logic [REG_AW-1:0] r_ex_rs;
    logic [REG_AW-1:0] r_ex_rt;
    logic              r_ex_v;

    dst_slot_t w_ex, w_mem, w_wb;
    logic      w_ex_hit, w_mem_hit;

    // The EX-stage destination comes straight from the datapath's rt/rd mux.
    assign w_ex = '{dst: ex_dst, rw: ex_reg_write & r_ex_v,
                    mr: ex_mem_read & r_ex_v, v: r_ex_v};

    dst_slot u_mem (
        .clk(clk), .reset_n(reset_n),
        .d_dst(w_ex.dst), .d_rw(w_ex.rw), .d_mr(w_ex.mr), .d_v(w_ex.v),
        .q_dst(w_mem.dst), .q_rw(w_mem.rw), .q_mr(w_mem.mr), .q_v(w_mem.v)
    );

    dst_slot u_wb (
        .clk(clk), .reset_n(reset_n),
        .d_dst(w_mem.dst), .d_rw(w_mem.rw), .d_mr(w_mem.mr), .d_v(w_mem.v),
        .q_dst(w_wb.dst), .q_rw(w_wb.rw), .q_mr(w_wb.mr), .q_v(w_wb.v)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ex_rs <= REG_ZERO;
            r_ex_rt <= REG_ZERO;
            r_ex_v  <= 1'b0;
        end else if (stall | flush) begin
            r_ex_rs <= REG_ZERO;
            r_ex_rt <= REG_ZERO;
            r_ex_v  <= 1'b0;
        end else begin
            r_ex_rs <= id_rs & {REG_AW{id_use_rs}};
            r_ex_rt <= id_rt & {REG_AW{id_use_rt}};
            r_ex_v  <= 1'b1;
        end
    end

    assign w_ex_hit  = (id_use_rs & slot_writes(w_ex, id_rs)) |
                       (id_use_rt & slot_writes(w_ex, id_rt));
    assign w_mem_hit = (id_use_rs & slot_writes(w_mem, id_rs)) |
                       (id_use_rt & slot_writes(w_mem, id_rt));

    // A load feeding a branch waits through both EX and MEM: two stall cycles.
    assign stall = (w_ex.mr & w_ex_hit) |
                   (id_is_branch & w_ex_hit) |
                   (id_is_branch & w_mem.mr & w_mem_hit);

    function automatic logic [FWD_W-1:0] fwd_sel(dst_slot_t m, dst_slot_t w,
                                                 logic [REG_AW-1:0] r);
        if (slot_writes(m, r))
            return m.mr ? (slot_writes(w, r) ? FWD_WB : FWD_RF) : FWD_MEM;
        else if (slot_writes(w, r))
            return FWD_WB;
        return FWD_RF;
    endfunction

    assign fwd_a = fwd_sel(w_mem, w_wb, r_ex_rs);
    assign fwd_b = fwd_sel(w_mem, w_wb, r_ex_rt);

    // WB results reach ID through the regfile's write-before-read.
    assign fwd_br_a = id_is_branch & ~w_mem.mr & slot_writes(w_mem, id_rs);
    assign fwd_br_b = id_is_branch & ~w_mem.mr & slot_writes(w_mem, id_rt);

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed-vector bench for hazard_forward_unit; expected values worked out by hand.
module tb_hazard_forward_unit;
    import hazard_forward_unit_pkg::*;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [REG_AW-1:0] id_rs, id_rt, ex_dst;
    logic              id_use_rs, id_use_rt, id_is_branch;
    logic              ex_reg_write, ex_mem_read, flush;
    logic              stall, fwd_br_a, fwd_br_b;
    logic [FWD_W-1:0]  fwd_a, fwd_b;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    hazard_forward_unit dut (
        .clk(clk), .reset_n(reset_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_is_branch(id_is_branch), .ex_dst(ex_dst), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .flush(flush), .stall(stall),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_br_a(fwd_br_a), .fwd_br_b(fwd_br_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input int rs, input int rt, input bit urs, input bit urt, input bit br);
        id_rs = rs[REG_AW-1:0];
        id_rt = rt[REG_AW-1:0];
        id_use_rs = urs;
        id_use_rt = urt;
        id_is_branch = br;
    endtask

    task automatic set_ex(input int dst, input bit rw, input bit mr);
        ex_dst = dst[REG_AW-1:0];
        ex_reg_write = rw;
        ex_mem_read = mr;
    endtask

    task automatic drain();
        set_id(0, 0, 0, 0, 0);
        set_ex(0, 0, 0);
        flush = 1'b0;
        repeat (3) cyc();
    endtask

    initial begin
        reset_n = 1'b1;
        flush = 1'b0;
        set_id(0, 0, 0, 0, 0);
        set_ex(0, 0, 0);
        #1 reset_n = 1'b0;
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_fwd", {fwd_a, fwd_b, fwd_br_a, fwd_br_b}, 0);
        #20 reset_n = 1'b1;
        cyc();

        // 1: add $1 then readers of $1 forward from MEM then WB
        set_id(7, 8, 1, 1, 0);
        cyc();
        set_ex(1, 1, 0); set_id(1, 9, 1, 0, 0); #1;
        chk("t1_nostall", stall, 0);
        cyc();
        set_ex(9, 1, 0); set_id(1, 0, 1, 0, 0); #1;
        chk("t1_fwd_mem", fwd_a, 2'b10);
        cyc();
        set_ex(0, 0, 0); set_id(0, 0, 0, 0, 0); #1;
        chk("t1_fwd_wb", fwd_a, 2'b01);
        drain();

        // 2: lw $2 followed by a use of $2 in rt
        set_id(10, 0, 1, 0, 0);
        cyc();
        set_ex(2, 1, 1); set_id(11, 2, 1, 1, 0); #1;
        chk("t2_stall", stall, 1);
        cyc();
        set_ex(0, 0, 0); #1;
        chk("t2_stall_end", stall, 0);
        chk("t2_bubble_fwd_b", fwd_b, 2'b00);
        cyc();
        set_ex(12, 1, 0); set_id(0, 0, 0, 0, 0); #1;
        chk("t2_fwd_b_wb", fwd_b, 2'b01);
        chk("t2_fwd_a_rf", fwd_a, 2'b00);
        drain();

        // 3: beq on $3 right behind add $3
        set_id(0, 0, 0, 0, 0);
        cyc();
        set_ex(3, 1, 0); set_id(3, 13, 1, 1, 1); #1;
        chk("t3_stall", stall, 1);
        chk("t3_brfwd_early", fwd_br_a, 0);
        cyc();
        set_ex(0, 0, 0); #1;
        chk("t3_stall_end", stall, 0);
        chk("t3_brfwd_a", {fwd_br_a, fwd_br_b}, 2'b10);
        drain();

        // flush squashes the reader of $14 so nothing forwards into EX
        set_id(0, 0, 0, 0, 0);
        cyc();
        set_ex(14, 1, 0); set_id(14, 0, 1, 0, 0); flush = 1'b1; #1;
        chk("flush_nostall", stall, 0);
        cyc();
        flush = 1'b0; set_ex(0, 0, 0); set_id(0, 0, 0, 0, 0); #1;
        chk("flush_bubble", fwd_a, 2'b00);
        drain();

        // 4: lw $4 feeding beq: two stall cycles, no branch forwarding
        set_id(0, 0, 0, 0, 0);
        cyc();
        set_ex(4, 1, 1); set_id(15, 4, 1, 1, 1); #1;
        chk("t4_stall1", stall, 1);
        cyc();
        set_ex(0, 0, 0); #1;
        chk("t4_stall2", stall, 1);
        chk("t4_brfwd_b_load", fwd_br_b, 0);
        cyc();
        #1;
        chk("t4_stall_end", stall, 0);
        chk("t4_brfwd_none", {fwd_br_a, fwd_br_b}, 2'b00);
        drain();

        // 5: writes to $0 never match; MEM beats WB on $5
        set_id(0, 0, 0, 0, 0);
        cyc();
        set_ex(0, 1, 0); cyc();
        set_ex(0, 1, 0); set_id(0, 0, 1, 1, 1); #1;
        chk("t5_zero_stall", stall, 0);
        chk("t5_zero_brfwd", {fwd_br_a, fwd_br_b}, 2'b00);
        cyc();
        set_ex(0, 0, 0); set_id(0, 0, 0, 0, 0); #1;
        chk("t5_zero_fwd", {fwd_a, fwd_b}, 4'b0000);
        cyc();
        set_ex(5, 1, 0); cyc();
        set_ex(5, 1, 0); set_id(5, 0, 1, 0, 0); #1;
        chk("t5_dual_nostall", stall, 0);
        cyc();
        set_ex(0, 0, 0); set_id(0, 0, 0, 0, 0); #1;
        chk("t5_mem_prio", fwd_a, 2'b10);
        drain();

        // 6: reset during a stall clears everything asynchronously
        set_id(0, 0, 0, 0, 0);
        cyc();
        set_ex(6, 1, 0); set_id(6, 0, 1, 0, 0); cyc();
        set_ex(7, 1, 1); set_id(0, 7, 0, 1, 0); #1;
        chk("t6_stall", stall, 1);
        chk("t6_fwd_a", fwd_a, 2'b10);
        reset_n = 1'b0; #1;
        chk("t6_rst_stall", stall, 0);
        chk("t6_rst_fwd", {fwd_a, fwd_b, fwd_br_a, fwd_br_b}, 0);
        #2 reset_n = 1'b1;
        set_ex(7, 1, 1); set_id(7, 0, 1, 0, 0); #1;
        chk("t6_post_nostall", stall, 0);
        cyc();
        set_ex(0, 0, 0); set_id(0, 0, 0, 0, 0); #1;
        chk("t6_post_fwd", fwd_a, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
